// File: rtl/id_scoreboard.sv
// id_scoreboard: destination-register lock table for the in-order pipeline.
// Decode asks for an issue grant each cycle, writeback releases locks, and a
// flush drops every lock. The block also limits outstanding writes and keeps
// a saturating count of hazard stall cycles.
module id_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 3,
    parameter int AW          = $clog2(NUM_REGS),
    parameter int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic                clk,
    input  logic                rstn_i,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rs1_i,
    input  logic [AW-1:0]       issue_rs2_i,
    input  logic                issue_use_rs1_i,
    input  logic                issue_use_rs2_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic                issue_wr_i,
    output logic                issue_ready_o,
    input  logic                wb_valid_i,
    input  logic [AW-1:0]       wb_rd_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] locks_o,
    output logic [PW-1:0]       pending_o,
    output logic [15:0]         stall_cnt_o
);

    // x0 has no storage; it reads back as permanently unlocked.
    logic [NUM_REGS-1:1] lock_q, lock_n;
    logic [NUM_REGS-1:0] lock_all;
    logic [PW-1:0]       pending_q, pending_n;
    logic [15:0]         stall_q;

    logic raw1, raw2, waw, full;
    logic fire, do_set, do_clr, stall_inc;

    assign lock_all = {lock_q, 1'b0};

    // Hazards look only at registered locks; a writeback in this cycle does
    // not unblock a dependant until the next cycle.
    assign raw1 = issue_use_rs1_i && (issue_rs1_i != '0) && lock_all[issue_rs1_i];
    assign raw2 = issue_use_rs2_i && (issue_rs2_i != '0) && lock_all[issue_rs2_i];
    assign waw  = issue_wr_i && (issue_rd_i != '0) && lock_all[issue_rd_i];
    assign full = issue_wr_i && (issue_rd_i != '0) && (pending_q == PW'(MAX_PENDING));

    // Grant is forced low while reset is held.
    assign issue_ready_o = rstn_i && !(raw1 || raw2 || waw || full);

    assign fire      = issue_valid_i && issue_ready_o && !flush_i;
    assign do_set    = fire && issue_wr_i && (issue_rd_i != '0);
    assign do_clr    = wb_valid_i && (wb_rd_i != '0) && lock_all[wb_rd_i];
    assign stall_inc = issue_valid_i && !issue_ready_o && !flush_i;

    // Next lock vector and pending count: release, then issue set, flush wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        lock_n    = lock_q;
        pending_n = pending_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (do_clr && (wb_rd_i == AW'(i)))
                lock_n[i] = 1'b0;
            if (do_set && (issue_rd_i == AW'(i)))
                lock_n[i] = 1'b1;
        end
        if (do_set && !do_clr)
            pending_n = pending_q + PW'(1);
        else if (do_clr && !do_set)
            pending_n = pending_q - PW'(1);
        if (flush_i) begin
            lock_n    = '0;
            pending_n = '0;
        end
    end

    // State registers: locks, pending count and saturating stall counter.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_q    <= '0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            lock_q    <= lock_n;
            pending_q <= pending_n;
            if (stall_inc && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign locks_o     = lock_all;
    assign pending_o   = pending_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenarios followed by random traffic, all
// checked against a register-lock model built from plain arrays.
module tb_id_scoreboard;

    localparam int NUM_REGS    = 32;
    localparam int MAX_PENDING = 3;
    localparam int AW          = $clog2(NUM_REGS);
    localparam int PW          = $clog2(MAX_PENDING + 1);

    logic                clk = 1'b0;
    logic                rstn_i;
    logic                issue_valid_i;
    logic [AW-1:0]       issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic                issue_use_rs1_i, issue_use_rs2_i, issue_wr_i;
    logic                issue_ready_o;
    logic                wb_valid_i;
    logic [AW-1:0]       wb_rd_i;
    logic                flush_i;
    logic [NUM_REGS-1:0] locks_o;
    logic [PW-1:0]       pending_o;
    logic [15:0]         stall_cnt_o;

    id_scoreboard #(.NUM_REGS(NUM_REGS), .MAX_PENDING(MAX_PENDING)) dut (
        .clk             (clk),
        .rstn_i          (rstn_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rs1_i     (issue_rs1_i),
        .issue_rs2_i     (issue_rs2_i),
        .issue_use_rs1_i (issue_use_rs1_i),
        .issue_use_rs2_i (issue_use_rs2_i),
        .issue_rd_i      (issue_rd_i),
        .issue_wr_i      (issue_wr_i),
        .issue_ready_o   (issue_ready_o),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_i         (wb_rd_i),
        .flush_i         (flush_i),
        .locks_o         (locks_o),
        .pending_o       (pending_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which registers are locked, and the stall count.
    bit locked [NUM_REGS];
    int stall_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 1; i < NUM_REGS; i++) n += int'(locked[i]);
        return n;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < NUM_REGS; i++) v[i] = locked[i];
        return v;
    endfunction

    function automatic bit model_ready();
        bit hz = 1'b0;
        if (issue_use_rs1_i && issue_rs1_i != 0 && locked[issue_rs1_i]) hz = 1'b1;
        if (issue_use_rs2_i && issue_rs2_i != 0 && locked[issue_rs2_i]) hz = 1'b1;
        if (issue_wr_i && issue_rd_i != 0 && locked[issue_rd_i]) hz = 1'b1;
        if (issue_wr_i && issue_rd_i != 0 && model_count() == MAX_PENDING) hz = 1'b1;
        return !hz;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_REGS; i++) locked[i] = 1'b0;
        stall_m = 0;
    endfunction

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr, input bit wbv, input int wbrd, input bit fl);
        issue_valid_i   = v;
        issue_rs1_i     = AW'(rs1);
        issue_use_rs1_i = u1;
        issue_rs2_i     = AW'(rs2);
        issue_use_rs2_i = u2;
        issue_rd_i      = AW'(rd);
        issue_wr_i      = wr;
        wb_valid_i      = wbv;
        wb_rd_i         = AW'(wbrd);
        flush_i         = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle with the currently driven inputs: check the grant,
    // advance the model across the edge, then check registered outputs.
    task automatic cycle(input string tag);
        bit rdy, fire, rel;
        #1;
        rdy = model_ready();
        check({tag, ":ready"}, 32'(issue_ready_o), 32'(rdy));
        fire = issue_valid_i && rdy && !flush_i;
        rel  = wb_valid_i && wb_rd_i != 0 && locked[wb_rd_i];
        if (issue_valid_i && !rdy && !flush_i && stall_m < 16'hFFFF) stall_m++;
        @(posedge clk);
        if (flush_i) begin
            for (int i = 0; i < NUM_REGS; i++) locked[i] = 1'b0;
        end else begin
            if (rel) locked[wb_rd_i] = 1'b0;
            if (fire && issue_wr_i && issue_rd_i != 0) locked[issue_rd_i] = 1'b1;
        end
        #1;
        check({tag, ":locks"}, 32'(locks_o), model_vec());
        check({tag, ":pending"}, 32'(pending_o), 32'(model_count()));
        check({tag, ":stall"}, 32'(stall_cnt_o), 32'(stall_m));
        check({tag, ":popcount"}, 32'(pending_o), 32'($countones(locks_o)));
    endtask

    initial begin
        // Reset state, with a hazard-free request that must still see no grant.
        rstn_i = 1'b0;
        model_clear();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        #12;
        check("rst:ready", 32'(issue_ready_o), 32'd0);
        check("rst:locks", 32'(locks_o), 32'd0);
        check("rst:pending", 32'(pending_o), 32'd0);
        check("rst:stall", 32'(stall_cnt_o), 32'd0);
        rstn_i = 1'b1;
        idle();
        @(posedge clk); #1;

        // RAW on rd=5, released by writeback; dependant issues the next cycle.
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle("raw_set");
        check("raw_lock5", 32'(locks_o[5]), 32'd1);
        check("raw_pend1", 32'(pending_o), 32'd1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("raw_stall");
        check("raw_stall3", 32'(stall_cnt_o), 32'd3);
        drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0); cycle("raw_wb");
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle("raw_go");
        check("raw_pend0", 32'(pending_o), 32'd0);

        // x0 as destination and source is never locked.
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle("x0_wr");
        drive(1, 0, 1, 0, 1, 0, 0, 1, 0, 0); cycle("x0_rd");
        check("x0_locks", 32'(locks_o), 32'd0);

        // Capacity limit.
        for (int r = 1; r <= 3; r++) begin
            drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0); cycle("cap_fill");
        end
        check("cap_pend3", 32'(pending_o), 32'd3);
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); cycle("cap_full");
        drive(1, 6, 1, 0, 0, 4, 0, 0, 0, 0); cycle("cap_nowr");
        drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 0); cycle("cap_wb_same");
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); cycle("cap_go");
        check("cap_pend3b", 32'(pending_o), 32'd3);
        check("cap_lock4", 32'(locks_o[4]), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("cap_flush");

        // WAW on rd=7 with same-cycle writeback.
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle("waw_set");
        drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 0); cycle("waw_wb");
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle("waw_go");
        check("waw_lock7", 32'(locks_o[7]), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("waw_flush");

        // Flush drops a same-cycle issue; a later writeback is a no-op.
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); cycle("fl_set2");
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); cycle("fl_set9");
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 1); cycle("fl_flush");
        check("fl_locks0", 32'(locks_o), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); cycle("fl_wb9");
        check("fl_pend0", 32'(pending_o), 32'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(1), $urandom_range(7), $urandom_range(1),
                  $urandom_range(7), $urandom_range(1), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1), $urandom_range(7),
                  $urandom_range(31) == 0);
            cycle("rand");
        end

        // Long stall: lock rd=5 and hold a dependant until saturation.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("sat_flush");
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle("sat_set");
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        stall_m = (stall_m + 70000 > 65535) ? 65535 : stall_m + 70000;
        check("sat_ffff", 32'(stall_cnt_o), 32'hFFFF);
        for (int i = 0; i < 3; i++) cycle("sat_hold");

        // Asynchronous reset in mid-cycle.
        rstn_i = 1'b0;
        #2;
        check("arst:locks", 32'(locks_o), 32'd0);
        check("arst:pending", 32'(pending_o), 32'd0);
        check("arst:stall", 32'(stall_cnt_o), 32'd0);
        check("arst:ready", 32'(issue_ready_o), 32'd0);
        model_clear();
        rstn_i = 1'b1;
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); cycle("post_rst");
        idle(); cycle("post_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-hazard scoreboard for the in-order pipeline. It sits beside the instruction decode stage and owns all destination-register locks. Decode queries it each cycle for an issue grant, and writeback releases locks through it. It also bounds the number of outstanding register writes and counts hazard stall cycles for performance analysis.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never locked.
- MAX_PENDING, 3, maximum simultaneously locked destination registers; must be 1..NUM_REGS-1.
- AW, $clog2(NUM_REGS), register address width.
- PW, $clog2(MAX_PENDING+1), pending-counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  decode holds an instruction requesting issue.
- issue_rs1_i  in  AW  source register 1 address.
- issue_rs2_i  in  AW  source register 2 address.
- issue_use_rs1_i  in  1  instruction reads rs1.
- issue_use_rs2_i  in  1  instruction reads rs2.
- issue_rd_i  in  AW  destination register address.
- issue_wr_i  in  1  instruction writes rd.
- issue_ready_o  out  1  combinational grant: no hazard and capacity available.
- wb_valid_i  in  1  writeback stage is retiring a register write this cycle.
- wb_rd_i  in  AW  register being written by writeback.
- flush_i  in  1  pipeline flush; discards the issue and clears all locks.
- locks_o  out  NUM_REGS  registered lock vector; bit 0 is always 0.
- pending_o  out  PW  registered count of locked registers.
- stall_cnt_o  out  16  saturating count of hazard stall cycles.

## Operation
- State: lock_q[NUM_REGS-1:1], pending_q, stall_q. Reset clears all of it; outputs are 0 during reset, including issue_ready_o.
- Hazard terms use registered state only (lock_q, pending_q); there is no same-cycle bypass from writeback.
  - raw1 = use_rs1 and rs1≠0 and lock_q[rs1].
  - raw2 = use_rs2 and rs2≠0 and lock_q[rs2].
  - waw = wr and rd≠0 and lock_q[rd].
  - full = wr and rd≠0 and pending_q == MAX_PENDING.
- Grant: issue_ready_o = rstn_i and !(raw1|raw2|waw|full). It does not depend on issue_valid_i.
- Issue fires when issue_valid_i & issue_ready_o & !flush_i. If wr and rd≠0, lock_n[rd] is set and pending increments by 1.
- Release: when wb_valid_i and wb_rd_i≠0 and lock_q[wb_rd_i], lock_n[wb_rd_i] is cleared and pending decrements by 1.
- A writeback to an unlocked register, or to x0, is a no-op. It is not an error, and pending never underflows.
- Same-cycle issue and release:
  - Apply the release first, then the issue set.
  - Pending net change is +1 −1 = 0.
  - Issue to the register being released cannot fire, because waw blocks it.
- Flush: lock_n is all 0 and pending_n = 0 next cycle, regardless of same-cycle issue or writeback.
  - Later writebacks from in-flight instructions become no-ops.
- Stall counter: increments by 1 in each cycle with issue_valid_i & !issue_ready_o & !flush_i. It saturates at 0xFFFF and is cleared only by reset.
- Invariant: pending_q == popcount(lock_q) at all times. The bench checks this every cycle.

## Timing
- Grant latency: 0 cycles, combinational from the issue_* inputs and registered state.
- A lock set by an issue in cycle N is visible in locks_o and blocks dependants from cycle N+1.
- A release in cycle N unblocks dependants from cycle N+1. A dependant waiting on a writeback therefore issues one cycle after the writeback cycle.
- Flush in cycle N: all locks are clear and issue_ready_o depends only on the new instruction from N+1. An issue in cycle N is dropped.
- Reset asserted mid-operation clears all state asynchronously. After rstn_i deasserts, issue_ready_o is 1 for a hazard-free request.

## Test plan
- Issue wr rd=5 with no hazards -> issue_ready_o=1; next cycle locks_o[5]=1, pending_o=1. Then issue rs1=5 -> ready=0, stall_cnt_o increments each cycle. wb rd=5 in cycle N -> ready=1 in N+1, pending_o=0.
- Issue rd=0 wr=1, then rs1=0 -> both granted; locks_o stays 0 and pending_o stays 0.
- MAX_PENDING=3: issue rd=1,2,3 -> pending_o=3. Issue rd=4 -> ready=0 (full), but a non-writing instruction is still granted. Same-cycle wb rd=1 plus issue rd=4 -> stall holds that cycle; rd=4 issues the next cycle and pending_o remains 3.
- With rd=7 locked, issue rd=7 -> waw stall. Same-cycle wb rd=7 -> next cycle issue granted and locks_o[7]=1 again.
- Lock rd=2,9 then assert flush_i together with issue_valid rd=4 -> next cycle locks_o=0 and pending_o=0, and rd=4 is not locked. A later wb rd=9 -> no change.
- Hold a stall for 70000 cycles -> stall_cnt_o=0xFFFF and stays there. Assert rstn_i=0 mid-run -> all outputs 0 immediately.
